// File: rtl/load_store_sequencer.sv
// Load/store sequencer: turns byte-addressed core requests into word-aligned memory
// transactions, splitting word-crossing accesses and merging/extending load data.
module load_store_sequencer #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWE,
    input  logic [31:0] ReqA,
    input  logic [2:0]  ReqType,
    input  logic [31:0] ReqWD,
    output logic        MemReq,
    output logic [31:0] MemA,
    output logic        MemWE,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWD,
    input  logic [31:0] MemRD,
    input  logic        MemAck,
    output logic        RespValid,
    output logic [31:0] RDOut,
    output logic        Misaligned
);

    typedef enum logic [1:0] {StIdle, StFirst, StSecond, StResp} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_type;
    logic [31:0] r_wd;
    logic [31:0] r_lo;
    logic [31:0] r_rdout;
    logic        r_mis;

    logic [7:0]  w_req_be8;
    logic        w_req_cross;
    logic [7:0]  w_be8;
    logic [63:0] w_wd64;
    logic        w_cross;
    logic [31:0] w_base;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [63:0] w_d64;
    logic [31:0] w_d;
    logic [31:0] w_ext;
    logic [31:0] w_result;

    function automatic logic [3:0] f_size_mask(input logic [2:0] t);
        case (t[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // An access crosses a word when any of its lanes lands in the upper word.
    assign w_req_be8   = {4'b0000, f_size_mask(ReqType)} << ReqA[1:0];
    assign w_req_cross = |w_req_be8[7:4];

    assign w_be8   = {4'b0000, f_size_mask(r_type)} << r_addr[1:0];
    assign w_wd64  = {32'b0, r_wd} << {r_addr[1:0], 3'b000};
    assign w_cross = |w_be8[7:4];
    assign w_base  = {r_addr[31:2], 2'b00};

    // Merge source: in FIRST the live read word is Lo; in SECOND it is Hi.
    assign w_hi  = (r_state == StSecond) ? MemRD : 32'b0;
    assign w_lo  = (r_state == StSecond) ? r_lo : MemRD;
    assign w_d64 = {w_hi, w_lo} >> {r_addr[1:0], 3'b000};
    assign w_d   = w_d64[31:0];

    always_comb begin
        w_ext = w_d;
        case (r_type)
            3'b000:  w_ext = {{24{w_d[7]}}, w_d[7:0]};
            3'b001:  w_ext = {{16{w_d[15]}}, w_d[15:0]};
            3'b100:  w_ext = {24'b0, w_d[7:0]};
            3'b101:  w_ext = {16'b0, w_d[15:0]};
            default: w_ext = w_d;
        endcase
    end

    assign w_result = r_we ? 32'b0 : w_ext;

    always_comb begin
        w_state_next = r_state;
        ReqReady     = 1'b0;
        MemReq       = 1'b0;
        MemA         = 32'b0;
        MemWE        = 1'b0;
        MemBE        = 4'b0;
        MemWD        = 32'b0;
        RespValid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    w_state_next = (w_req_cross && !SPLIT_EN) ? StResp : StFirst;
                end
            end
            StFirst: begin
                MemReq = 1'b1;
                MemA   = w_base;
                MemWE  = r_we;
                MemBE  = w_be8[3:0];
                MemWD  = w_wd64[31:0];
                if (MemAck) begin
                    w_state_next = w_cross ? StSecond : StResp;
                end
            end
            StSecond: begin
                MemReq = 1'b1;
                MemA   = w_base + 32'd4;
                MemWE  = r_we;
                MemBE  = w_be8[7:4];
                MemWD  = w_wd64[63:32];
                if (MemAck) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                RespValid    = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign RDOut      = r_rdout;
    assign Misaligned = (r_state == StResp) && r_mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_addr  <= 32'b0;
            r_type  <= 3'b0;
            r_wd    <= 32'b0;
            r_lo    <= 32'b0;
            r_rdout <= 32'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (ReqValid) begin
                        r_we   <= ReqWE;
                        r_addr <= ReqA;
                        r_type <= ReqType;
                        r_wd   <= ReqWD;
                        r_mis  <= w_req_cross && !SPLIT_EN;
                        if (w_req_cross && !SPLIT_EN) begin
                            r_rdout <= 32'b0;
                        end
                    end
                end
                StFirst: begin
                    if (MemAck) begin
                        r_lo <= MemRD;
                        if (!w_cross) begin
                            r_rdout <= w_result;
                        end
                    end
                end
                StSecond: begin
                    if (MemAck) begin
                        r_rdout <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Scoreboard bench: byte-level memory model predicts transactions and responses;
// a memory responder and a response monitor check the DUT independently of stimulus.
module tb_load_store_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ReqValid = 1'b0, ReqValid2 = 1'b0;
    logic        ReqReady, ReqReady2;
    logic        ReqWE = 1'b0;
    logic [31:0] ReqA = '0;
    logic [2:0]  ReqType = '0;
    logic [31:0] ReqWD = '0;
    logic        MemReq, MemWE, MemReq2, MemWE2;
    logic [31:0] MemA, MemWD, MemA2, MemWD2;
    logic [3:0]  MemBE, MemBE2;
    logic [31:0] MemRD = '0;
    logic        MemAck = 1'b0;
    logic [31:0] MemRD2 = '0;
    logic        MemAck2 = 1'b0;
    logic        RespValid, Misaligned, RespValid2, Misaligned2;
    logic [31:0] RDOut, RDOut2;

    load_store_sequencer #(.SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWE(ReqWE),
        .ReqA(ReqA), .ReqType(ReqType), .ReqWD(ReqWD), .MemReq(MemReq), .MemA(MemA),
        .MemWE(MemWE), .MemBE(MemBE), .MemWD(MemWD), .MemRD(MemRD), .MemAck(MemAck),
        .RespValid(RespValid), .RDOut(RDOut), .Misaligned(Misaligned)
    );

    load_store_sequencer #(.SPLIT_EN(1'b0)) u_dut_nosplit (
        .clk(clk), .reset(reset), .ReqValid(ReqValid2), .ReqReady(ReqReady2), .ReqWE(ReqWE),
        .ReqA(ReqA), .ReqType(ReqType), .ReqWD(ReqWD), .MemReq(MemReq2), .MemA(MemA2),
        .MemWE(MemWE2), .MemBE(MemBE2), .MemWD(MemWD2), .MemRD(MemRD2), .MemAck(MemAck2),
        .RespValid(RespValid2), .RDOut(RDOut2), .Misaligned(Misaligned2)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } txn_t;

    resp_t       exp_resp[$];
    txn_t        exp_txn[$];
    logic [31:0] wmem[bit [31:0]];
    logic [7:0]  bmem[bit [31:0]];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wait_mode = 0;
    int          mreq2_seen = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [7:0] model_byte(logic [31:0] b);
        logic [31:0] w;
        if (bmem.exists(b)) return bmem[b];
        w = init_word({b[31:2], 2'b00}) >> (8 * b[1:0]);
        return w[7:0];
    endfunction

    function automatic int size_of(logic [2:0] t);
        if (t[1:0] == 2'b00) return 1;
        if (t[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] lane_mask(logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic poke_word(logic [31:0] a, logic [31:0] w);
        wmem[a] = w;
        for (int i = 0; i < 4; i++) bmem[a + i] = w[8*i +: 8];
    endtask

    // Memory responder: random or fixed wait, checks every transaction against the model.
    initial begin
        bit          in_txn = 0;
        int          wcnt = 0;
        logic [31:0] rd;
        txn_t        t;
        forever begin
            @(negedge clk);
            MemAck = 1'b0;
            MemRD  = $urandom;
            if (!MemReq) begin
                in_txn = 0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1;
                    wcnt = (wait_mode >= 0) ? wait_mode : int'($urandom_range(0, 3));
                end
                if (wcnt == 0) begin
                    in_txn = 0;
                    rd = wmem.exists(MemA) ? wmem[MemA] : init_word(MemA);
                    MemRD  = rd;
                    MemAck = 1'b1;
                    if (exp_txn.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn: got MemReq at 0x%08h, expected none", MemA);
                    end else begin
                        t = exp_txn.pop_front();
                        check("mem_addr", MemA, t.a);
                        check("mem_be", 32'(MemBE), 32'(t.be));
                        check("mem_we", 32'(MemWE), 32'(t.we));
                        if (t.we) begin
                            check("mem_wd", MemWD & lane_mask(t.be), t.wd & lane_mask(t.be));
                            wmem[MemA] = (rd & ~lane_mask(MemBE)) | (MemWD & lane_mask(MemBE));
                        end
                    end
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (RespValid === 1'b1) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got RespValid=1, expected no response");
                end else begin
                    r = exp_resp.pop_front();
                    check("rdout", RDOut, r.rd);
                    check("misaligned", 32'(Misaligned), 32'(r.mis));
                    if (r.lat >= 0) check("latency", 32'(cyc - r.acc), 32'(r.lat));
                end
            end
            if (MemReq2 === 1'b1) mreq2_seen++;
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] ty,
                         input logic [31:0] wd, input int wmode, input bit use_k,
                         input logic [31:0] k_rd);
        int          sz;
        int          ntx;
        int          n;
        bit          have;
        logic [31:0] b;
        logic [31:0] wa;
        logic [31:0] val;
        txn_t        t;
        resp_t       r;
        sz = size_of(ty);
        ntx = 0;
        have = 0;
        val = '0;
        t = '{a: '0, be: '0, we: 1'b0, wd: '0};
        for (int k = 0; k < sz; k++) begin
            b = a + k;
            wa = {b[31:2], 2'b00};
            if (!have || wa != t.a) begin
                if (have) exp_txn.push_back(t);
                t = '{a: wa, be: 4'b0, we: we, wd: 32'b0};
                have = 1;
                ntx++;
            end
            t.be[b[1:0]] = 1'b1;
            t.wd[8*b[1:0] +: 8] = wd[8*k +: 8];
            if (we) bmem[b] = wd[8*k +: 8];
            else val[8*k +: 8] = model_byte(b);
        end
        exp_txn.push_back(t);
        if (we) val = '0;
        else if (ty == 3'b000 && val[7]) val[31:8] = '1;
        else if (ty == 3'b001 && val[15]) val[31:16] = '1;
        r.rd  = use_k ? k_rd : val;
        r.mis = 1'b0;
        r.lat = (wmode >= 0) ? 1 + ntx * (1 + wmode) : -1;
        n = 0;
        @(negedge clk);
        while (!ReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(ReqReady), 32'd1);
        wait_mode = wmode;
        ReqWE = we;
        ReqA = a;
        ReqType = ty;
        ReqWD = wd;
        ReqValid = 1'b1;
        r.acc = cyc;
        @(posedge clk);
        exp_resp.push_back(r);
        #1 ReqValid = 1'b0;
    endtask

    task automatic issue_nosplit(input logic we, input logic [31:0] a, input logic [2:0] ty,
                                 input logic [31:0] wd);
        int n;
        int acc;
        n = 0;
        @(negedge clk);
        while (!ReqReady2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ReqWE = we;
        ReqA = a;
        ReqType = ty;
        ReqWD = wd;
        ReqValid2 = 1'b1;
        acc = cyc;
        @(posedge clk);
        #1 ReqValid2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!RespValid2 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("nosplit_resp", 32'(RespValid2), 32'd1);
        check("nosplit_latency", 32'(cyc - acc), 32'd1);
        check("nosplit_rdout", RDOut2, 32'd0);
        check("nosplit_misaligned", 32'(Misaligned2), 32'd1);
    endtask

    initial begin
        logic [2:0]  types[8];
        logic [31:0] a;
        logic [2:0]  ty;
        int          n;
        types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_memwe", 32'(MemWE), 32'd0);
        check("rst_membe", 32'(MemBE), 32'd0);
        check("rst_mema", MemA, 32'd0);
        check("rst_memwd", MemWD, 32'd0);
        check("rst_resp", 32'(RespValid), 32'd0);
        check("rst_rdout", RDOut, 32'd0);
        check("rst_mis", 32'(Misaligned), 32'd0);
        check("rst_ready", 32'(ReqReady), 32'd1);
        reset = 1'b0;

        poke_word(32'h1000, 32'hA1B2C3D4);
        poke_word(32'h1004, 32'h55667788);
        issue(1'b0, 32'h1002, 3'b000, 32'h0, 0, 1, 32'hFFFFFFB2);
        issue(1'b0, 32'h1002, 3'b100, 32'h0, 0, 1, 32'h000000B2);
        issue(1'b0, 32'h1002, 3'b001, 32'h0, 0, 1, 32'hFFFFA1B2);
        issue(1'b0, 32'h1002, 3'b101, 32'h0, 0, 1, 32'h0000A1B2);
        issue(1'b0, 32'h1003, 3'b010, 32'h0, 2, 1, 32'h667788A1);
        issue(1'b1, 32'h1003, 3'b001, 32'h0000BEEF, 1, 1, 32'h0);
        issue(1'b0, 32'hFFFFFFFE, 3'b010, 32'h0, 0, 0, 32'h0);
        issue_nosplit(1'b0, 32'hFFFFFFFE, 3'b010, 32'h0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + $urandom_range(0, 7);
            else a = 32'h2000 + $urandom_range(0, 63);
            issue(1'($urandom_range(0, 1)), a, types[$urandom_range(0, 7)], $urandom, -1, 0, 0);
        end

        for (int i = 0; i < 10; i++) begin
            ty = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
            a = 32'h4000 + 4 * $urandom_range(0, 15);
            a[1:0] = (ty == 3'b010) ? 2'($urandom_range(1, 3)) : 2'd3;
            issue_nosplit(1'($urandom_range(0, 1)), a, ty, $urandom);
        end

        // Abort a split load while its second transaction is outstanding.
        n = 0;
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h3002, 3'b010, 32'h0, 5, 0, 0);
        @(negedge clk);
        while (!(MemReq && exp_txn.size() == 1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_second", 32'(exp_txn.size()), 32'd1);
        #2 reset = 1'b1;
        #1 check("abort_memreq", 32'(MemReq), 32'd0);
        check("abort_rdout", RDOut, 32'd0);
        exp_resp.delete();
        exp_txn.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ReqReady), 32'd1);
        issue(1'b0, 32'h1004, 3'b010, 32'h0, 0, 0, 0);

        n = 0;
        while (exp_resp.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("resp_drain", 32'(exp_resp.size()), 32'd0);
        check("txn_drain", 32'(exp_txn.size()), 32'd0);
        check("nosplit_memreq_cycles", 32'(mreq2_seen), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Sequences every data-memory load/store issued by the core; sits between execute stage and the word-wide data memory.
- Converts byte address + Type (funct3) into word-aligned memory transactions with byte enables.
- Splits accesses that cross a word boundary into two back-to-back transactions.
- Merges, shifts and sign/zero-extends load data before returning it with a one-cycle response pulse.

Parameters:
- SPLIT_EN, 1, 1 = split word-crossing accesses; 0 = reject them with Misaligned and perform no memory access.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  core request valid.
- ReqReady  output  1  sequencer accepts request; high only in IDLE.
- ReqWE  input  1  1 = store, 0 = load.
- ReqA  input  32  byte address.
- ReqType  input  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others act as word.
- ReqWD  input  32  store data, right-justified.
- MemReq  output  1  memory transaction request; held until MemAck.
- MemA  output  32  word-aligned address, bits [1:0] = 0.
- MemWE  output  1  write strobe for the current transaction.
- MemBE  output  4  byte enables; bit i = byte lane i.
- MemWD  output  32  lane-aligned write data.
- MemRD  input  32  read data; valid in the MemAck cycle.
- MemAck  input  1  transaction complete, any latency ≥ 0 cycles after MemReq rises.
- RespValid  output  1  one-cycle completion pulse.
- RDOut  output  32  extended load result; 0 for stores.
- Misaligned  output  1  qualifies RespValid: access was rejected.

Behaviour:
- Reset, asynchronous: state IDLE, MemReq=0, MemWE=0, MemBE=0, MemA=0, MemWD=0, RespValid=0, RDOut=0, Misaligned=0. MemReq drops in the same instant as reset, including mid-transaction. No response is produced for an aborted request.
- States: IDLE, FIRST, SECOND, RESP.
- IDLE:
  - ReqReady=1.
  - When ReqValid=1, latch WE, A, Type, WD.
  - Size = 1, 2 or 4 bytes.
  - Off = A[1:0].
  - Cross = (Off + Size > 4).
  - If Cross and SPLIT_EN=0, go to RESP with Misaligned=1.
  - Otherwise go to FIRST.
- Lane computation, 8 lanes across two words:
  - BE8 = sizemask << Off.
  - WD64 = WD << 8*Off.
  - FIRST drives MemA = {A[31:2],2'b00}, MemBE = BE8[3:0], MemWD = WD64[31:0].
  - SECOND drives MemA = FIRST address + 4, modulo 2^32 (wraps to 0), MemBE = BE8[7:4], MemWD = WD64[63:32].
  - MemWE = latched WE. For loads, MemBE still shows the lanes used.
- FIRST:
  - MemReq=1; MemA/MemBE/MemWD held stable until MemAck.
  - On MemAck, capture MemRD as Lo.
  - Go to SECOND if Cross, else RESP.
- SECOND:
  - MemReq=1 from the first cycle after FIRST's ack.
  - On MemAck, capture MemRD as Hi and go to RESP.
- RESP:
  - RespValid=1 for exactly one cycle; RDOut and Misaligned valid in that cycle; then IDLE.
  - RDOut at all other times is held at its last value.
- Load merge:
  - D = ({Hi,Lo} >> 8*Off)[31:0], with Hi=0 when not split.
  - lb/lh sign-extend bit 7/15.
  - lbu/lhu zero-extend.
  - Word types pass D unchanged.
- Latency, ack in the same cycle as MemReq:
  - Request accepted in cycle 0.
  - MemReq in cycle 1.
  - Unsplit: RespValid in cycle 2.
  - Split: second MemReq in cycle 2, RespValid in cycle 3.
  - Memory wait cycles add directly.
- Misaligned rejection: no MemReq, RespValid in cycle 1, RDOut=0.
- Back-to-back: earliest next acceptance is the cycle after RespValid; ReqValid during busy states is ignored, and the core must hold it.
- MemAck outside FIRST/SECOND is ignored.
- Stores: RDOut=0, Misaligned=0 at RespValid.

Test Plan:
- Aligned lb, ReqA=0x1002, memory word 0x1000=0xA1B2C3D4, ack 0 wait → MemBE=0100, RDOut=0xFFFFFFB2, RespValid in cycle 2; lbu at the same address → 0x000000B2.
- lh at 0x1002, same word → single access with MemBE=1100, RDOut=0xFFFFA1B2; lhu → 0x0000A1B2.
- Split lw at 0x1003, words 0x1000=0xA1B2C3D4 and 0x1004=0x55667788, 2 wait states each:
  - Accesses go to 0x1000 (BE 1000) then 0x1004 (BE 0111).
  - RDOut=0x667788A1, RespValid 1 cycle after the second ack.
- Split sh at 0x1003, WD=0x0000BEEF:
  - First access: MemA=0x1000, BE=1000, WD=0xEF000000, MemWE=1.
  - Second access: MemA=0x1004, BE=0001, WD=0x000000BE.
  - At RespValid, RDOut=0.
- lw at 0xFFFFFFFE → second MemA=0x00000000 (wrap); with SPLIT_EN=0 the same request → no MemReq, RespValid+Misaligned in cycle 1.
- Assert reset while in SECOND with MemReq=1 → MemReq=0 immediately, no RespValid ever, ReqReady=1 after release; the next aligned lw completes normally.
